sdram_ctrl_fsm: RTL
===================

// Module: sdram_ctrl_fsm
// PURPOSE
//  Parametrised SDRAM control engine: own init and work FSMs, periodic auto-refresh, and a
//  valid/ready request port for 1..2^COL_W-word full-page bursts ended by BURST TERMINATE.
//  Drives registered command, bank and address pins, plus per-beat strobes for the external
//  data path. Sits between the system bus arbiter and the SDRAM pins.
// PARAMETERS
//  BA_W=2       bank address width
//  ROW_W=13     row address width; also the width of sdram_addr
//  COL_W=9      column width; maximum burst length = 2^COL_W
//  LEN_W=10     width of req_len
//  CAS_LAT=3    CAS latency, 2 or 3; written into the MRS command
//  T_INIT=20000 power-up wait in cycles (200us at 100MHz)
//  T_RP=2       cycles from PRECHARGE to the next command
//  T_RFC=7      cycles from AUTO REFRESH to the next command
//  T_MRD=2      cycles from MRS to the next command
//  T_RCD=2      cycles from ACTIVE to READ/WRITE
//  T_REF=780    refresh interval in cycles (7.8us)
// PORTS
//  clk_100m      in  1                 system clock
//  rst_n         in  1                 synchronous, active-low reset
//  req_valid     in  1                 request present
//  req_ready     out 1                 request accepted on valid&ready
//  req_wr        in  1                 1=write, 0=read
//  req_addr      in  BA_W+ROW_W+COL_W  {bank,row,col}
//  req_len       in  LEN_W             beats, 1..2^COL_W
//  init_done     out 1                 init sequence complete
//  busy          out 1                 FSM not in IDLE
//  wr_beat       out 1                 write beat must be on DQ this cycle
//  rd_beat       out 1                 read beat valid on DQ this cycle
//  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out 1 each  command pins
//  sdram_ba      out BA_W              bank select
//  sdram_addr    out ROW_W             row, column or mode address
// BEHAVIOUR
//  Commands {cke,cs_n,ras_n,cas_n,we_n}:
//  - INIT=01111, NOP=10111, PRE=10010, AR=10001, MRS=10000
//  - ACT=10011, RD=10101, WR=10100, BST=10110
//  Pin and strobe timing: all pins and strobes are registered. "Cycle n" = the cycle the
//  command is on the pins.
//  Reset (rst_n low at an edge):
//  - pins=INIT, ba and addr all ones; req_ready, init_done, busy, wr_beat, rd_beat all 0
//  - refresh counter cleared; init restarts from the full T_INIT wait
//  - applies equally mid-burst
//  Init sequence (NOP between commands):
//  - after T_INIT cycles: PRE with A10=1, wait T_RP; AR, wait T_RFC; AR, wait T_RFC
//  - MRS with BA=0, addr={0..0, A9=0, A8:7=00, A6:4=CAS_LAT, A3=0, A2:0=111}
//  - wait T_MRD, then init_done=1 (stays 1 until reset) and go to IDLE
//  Work FSM:
//  - states: IDLE, ACT, TRCD, RW, BURST, BST, PRE, TRP, AR, TRFC
//  - req_ready=1 only in IDLE with init_done=1 and no pending refresh
//  - on acceptance: capture addr, len and wr; issue ACT(ba, row); wait T_RCD; issue RD/WR with
//    ba and addr={0,col}, A10=0
//  - BST at cycle n+len; PRE all at n+len+1; wait T_RP; return to IDLE
//  - write: wr_beat=1 on cycles n..n+len-1
//  - read: rd_beat=1 on cycles n+CAS_LAT..n+CAS_LAT+len-1; BST/PRE truncate nothing valid
//  - req_len=0 is treated as 1
//  - col+len beyond 2^COL_W wraps to column 0 of the same row; no row crossing
//  Refresh:
//  - counter runs from init_done; each T_REF cycles it sets ref_pending
//  - a burst is never interrupted
//  - in IDLE, ref_pending beats req_valid: AR, wait T_RFC, clear ref_pending
//  - a second expiry while ref_pending is set is not counted
//  - req_valid and ref expiry in the same cycle: AR wins
// TESTING
//  1. T_INIT=10: PRE at cycle 10; AR at 10+T_RP and at 10+T_RP+T_RFC; MRS addr=0x037;
//     init_done T_MRD cycles after MRS.
//  2. Write len=4 at bank 2, row 0x1A5, col 0x010: ACT ba=2 addr=0x1A5; WR at +T_RCD with
//     addr=0x010; wr_beat 4 cycles; BST at WR+4; PRE addr[10]=1 at WR+5; req_ready again
//     T_RP later.
//  3. Read len=1, CAS_LAT=3: rd_beat single cycle at RD+3; BST at RD+1.
//  4. ref_pending set during a 512-beat write: burst completes; AR follows PRE+T_RP; a
//     queued req_valid is accepted only after T_RFC.
//  5. rst_n low for 1 cycle mid-burst: pins=01111, ba=11, strobes 0, init_done=0; full
//     init replays.
//  6. col=0x1FE len=4: exactly 4 wr_beat cycles; BST at WR+4; no extra ACT.

Source files
------------

// File: rtl/sdram_ctrl_fsm.sv
// SDRAM control engine: power-up init, full-page bursts ended by BURST TERMINATE,
// and periodic auto-refresh. All command pins and data-path strobes are registered.
module sdram_ctrl_fsm #(
   parameter int BA_W    = 2,
   parameter int ROW_W   = 13,
   parameter int COL_W   = 9,
   parameter int LEN_W   = 10,
   parameter int CAS_LAT = 3,
   parameter int T_INIT  = 20000,
   parameter int T_RP    = 2,
   parameter int T_RFC   = 7,
   parameter int T_MRD   = 2,
   parameter int T_RCD   = 2,
   parameter int T_REF   = 780
) (
   input  logic                          clk_100m,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_wr,
   input  logic [BA_W+ROW_W+COL_W-1:0]   req_addr,
   input  logic [LEN_W-1:0]              req_len,
   output logic                          init_done,
   output logic                          busy,
   output logic                          wr_beat,
   output logic                          rd_beat,
   output logic                          sdram_cke,
   output logic                          sdram_cs_n,
   output logic                          sdram_ras_n,
   output logic                          sdram_cas_n,
   output logic                          sdram_we_n,
   output logic [BA_W-1:0]               sdram_ba,
   output logic [ROW_W-1:0]              sdram_addr
);

   localparam logic [4:0] CMD_INIT = 5'b01111;
   localparam logic [4:0] CMD_NOP  = 5'b10111;
   localparam logic [4:0] CMD_PRE  = 5'b10010;
   localparam logic [4:0] CMD_AR   = 5'b10001;
   localparam logic [4:0] CMD_MRS  = 5'b10000;
   localparam logic [4:0] CMD_ACT  = 5'b10011;
   localparam logic [4:0] CMD_RD   = 5'b10101;
   localparam logic [4:0] CMD_WR   = 5'b10100;
   localparam logic [4:0] CMD_BST  = 5'b10110;

   localparam int CNT_W = ($clog2(T_INIT + 1) > LEN_W) ? $clog2(T_INIT + 1) : LEN_W;
   localparam int REF_W = $clog2(T_REF + 1);

   localparam logic [ROW_W-1:0] ADDR_A10  = ROW_W'(1) << 10;
   localparam logic [ROW_W-1:0] MODE_WORD = ROW_W'({3'(CAS_LAT), 1'b0, 3'b111});

   typedef enum logic [3:0] {
      S_I_WAIT, S_I_PRE, S_I_AR1, S_I_AR2, S_I_MRS,
      S_IDLE, S_ACT, S_TRCD, S_RW, S_BURST, S_BST, S_PRE, S_TRP, S_AR, S_TRFC
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [4:0]          r_cmd;
   logic [BA_W-1:0]     r_ba;
   logic [ROW_W-1:0]    r_addr;
   logic                r_init_done;
   logic                r_busy;
   logic                r_wr_beat;
   logic                r_rd_issue;
   logic [CAS_LAT-1:0]  r_rd_sr;
   logic [REF_W-1:0]    r_ref_cnt;
   logic                r_ref_pend;
   logic                r_wr;
   logic [BA_W-1:0]     r_bank;
   logic [COL_W-1:0]    r_col;
   logic [LEN_W-1:0]    r_len_m1;

   logic                w_ref_expire;
   logic                w_cnt_zero;
   logic [BA_W-1:0]     w_req_ba;
   logic [ROW_W-1:0]    w_req_row;
   logic [COL_W-1:0]    w_req_col;
   logic [LEN_W-1:0]    w_len_m1;
   logic [ROW_W-1:0]    w_col_addr;

   assign w_req_ba   = req_addr[BA_W+ROW_W+COL_W-1 -: BA_W];
   assign w_req_row  = req_addr[ROW_W+COL_W-1 -: ROW_W];
   assign w_req_col  = req_addr[COL_W-1:0];
   // A zero length is served as a single beat.
   assign w_len_m1   = (req_len == '0) ? '0 : req_len - LEN_W'(1);
   assign w_cnt_zero = (r_cnt == '0);
   assign w_ref_expire = r_init_done && (r_ref_cnt == REF_W'(T_REF - 1));

   always_comb begin
      w_col_addr              = '0;
      w_col_addr[COL_W-1:0]   = r_col;
      w_col_addr[10]          = 1'b0;
   end

   // An expiring refresh interval already blocks acceptance in that same cycle.
   assign req_ready = (r_state == S_IDLE) && r_init_done && !r_ref_pend && !w_ref_expire;

   always_ff @(posedge clk_100m) begin
      if (!rst_n) begin
         r_ref_cnt <= '0;
      end else if (r_init_done) begin
         r_ref_cnt <= w_ref_expire ? '0 : r_ref_cnt + REF_W'(1);
      end
   end

   always_ff @(posedge clk_100m) begin
      if (!rst_n) begin
         r_rd_sr <= '0;
      end else begin
         r_rd_sr <= {r_rd_sr[CAS_LAT-2:0], r_rd_issue};
      end
   end

   always_ff @(posedge clk_100m) begin
      if (!rst_n) begin
         r_state     <= S_I_WAIT;
         r_cnt       <= '0;
         r_cmd       <= CMD_INIT;
         r_ba        <= '1;
         r_addr      <= '1;
         r_init_done <= 1'b0;
         r_busy      <= 1'b0;
         r_wr_beat   <= 1'b0;
         r_rd_issue  <= 1'b0;
         r_ref_pend  <= 1'b0;
         r_wr        <= 1'b0;
         r_bank      <= '0;
         r_col       <= '0;
         r_len_m1    <= '0;
      end else begin
         r_cmd      <= CMD_NOP;
         r_wr_beat  <= 1'b0;
         r_rd_issue <= 1'b0;
         r_busy     <= 1'b1;
         case (r_state)
            S_I_WAIT: begin
               r_cmd <= CMD_INIT;
               if (r_cnt == CNT_W'(T_INIT - 1)) begin
                  r_cmd   <= CMD_PRE;
                  r_addr  <= ADDR_A10;
                  r_cnt   <= CNT_W'(T_RP - 1);
                  r_state <= S_I_PRE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_I_PRE, S_I_AR1: begin
               if (w_cnt_zero) begin
                  r_cmd   <= CMD_AR;
                  r_cnt   <= CNT_W'(T_RFC - 1);
                  r_state <= (r_state == S_I_PRE) ? S_I_AR1 : S_I_AR2;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_I_AR2: begin
               if (w_cnt_zero) begin
                  r_cmd   <= CMD_MRS;
                  r_ba    <= '0;
                  r_addr  <= MODE_WORD;
                  r_cnt   <= CNT_W'(T_MRD - 1);
                  r_state <= S_I_MRS;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_I_MRS: begin
               if (w_cnt_zero) begin
                  r_init_done <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_IDLE: begin
               if (r_ref_pend || w_ref_expire) begin
                  r_cmd   <= CMD_AR;
                  r_cnt   <= CNT_W'(T_RFC - 1);
                  r_state <= S_AR;
               end else if (req_valid) begin
                  r_wr     <= req_wr;
                  r_bank   <= w_req_ba;
                  r_col    <= w_req_col;
                  r_len_m1 <= w_len_m1;
                  r_cmd    <= CMD_ACT;
                  r_ba     <= w_req_ba;
                  r_addr   <= w_req_row;
                  r_cnt    <= CNT_W'(T_RCD - 1);
                  r_state  <= S_ACT;
               end else begin
                  r_busy <= 1'b0;
               end
            end
            S_ACT, S_TRCD: begin
               if (w_cnt_zero) begin
                  r_cmd      <= r_wr ? CMD_WR : CMD_RD;
                  r_ba       <= r_bank;
                  r_addr     <= w_col_addr;
                  r_wr_beat  <= r_wr;
                  r_rd_issue <= !r_wr;
                  r_cnt      <= CNT_W'(r_len_m1);
                  r_state    <= S_RW;
               end else begin
                  r_cnt   <= r_cnt - CNT_W'(1);
                  r_state <= S_TRCD;
               end
            end
            // Full-page mode wraps inside the open row, so no column tracking is needed.
            S_RW, S_BURST: begin
               if (w_cnt_zero) begin
                  r_cmd   <= CMD_BST;
                  r_state <= S_BST;
               end else begin
                  r_wr_beat  <= r_wr;
                  r_rd_issue <= !r_wr;
                  r_cnt      <= r_cnt - CNT_W'(1);
                  r_state    <= S_BURST;
               end
            end
            S_BST: begin
               r_cmd   <= CMD_PRE;
               r_addr  <= ADDR_A10;
               r_cnt   <= CNT_W'(T_RP - 1);
               r_state <= S_PRE;
            end
            S_PRE, S_TRP: begin
               if (!w_cnt_zero) begin
                  r_cnt   <= r_cnt - CNT_W'(1);
                  r_state <= S_TRP;
               end else if (r_ref_pend || w_ref_expire) begin
                  r_cmd   <= CMD_AR;
                  r_cnt   <= CNT_W'(T_RFC - 1);
                  r_state <= S_AR;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_AR, S_TRFC: begin
               if (w_cnt_zero) begin
                  r_ref_pend <= 1'b0;
                  r_busy     <= 1'b0;
                  r_state    <= S_IDLE;
               end else begin
                  r_cnt   <= r_cnt - CNT_W'(1);
                  r_state <= S_TRFC;
               end
            end
            default: begin
               r_cnt   <= '0;
               r_state <= S_I_WAIT;
            end
         endcase
         // A fresh expiry always wins over the clear at the end of tRFC.
         if (w_ref_expire) begin
            r_ref_pend <= 1'b1;
         end
      end
   end

   assign {sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = r_cmd;
   assign sdram_ba   = r_ba;
   assign sdram_addr = r_addr;
   assign init_done  = r_init_done;
   assign busy       = r_busy;
   assign wr_beat    = r_wr_beat;
   assign rd_beat    = r_rd_sr[CAS_LAT-1];

endmodule
